// File: rtl/clk_int_div_dyn.sv
// Runtime-programmable integer clock divider.
// A new ratio is accepted through a valid/ready handshake and applied only at
// a period boundary, so clk_o never glitches. Every output is driven straight
// from a flop; each flop's next value is derived from next-state/next-count.
module clk_int_div_dyn #(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int DONE_DELAY  = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 div_valid_i,
  output logic                 div_ready_o,
  output logic                 div_err_o,
  output logic                 div_done_o,
  output logic [DIV_WIDTH-1:0] clk_cnt_o,
  output logic                 clk_trg_o,
  output logic                 clk_o
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [DIV_WIDTH-1:0] DEF_DIV  = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE      = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] TWO      = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH:0]   ONE_WIDE = (DIV_WIDTH+1)'(1);
  localparam logic [3:0]           DONE_MAX = 4'(DONE_DELAY);

  state_t               state, state_n;
  logic [DIV_WIDTH-1:0] cur_div, cur_div_n;
  logic [DIV_WIDTH-1:0] pend_div, pend_div_n;
  logic                 pend_vld, pend_vld_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n;
  logic [3:0]           done_cnt, done_cnt_n;
  logic                 accept;
  logic                 boundary;
  logic [DIV_WIDTH:0]   half_n;
  logic                 clk_n, trg_n, err_n, ready_n, done_n;

  // Next-state logic: period counting, ratio application and handshake capture.
  // The half-period threshold is built one bit wider so a ratio of all ones
  // cannot overflow when rounded up.
  always_comb begin
    state_n    = state;
    cur_div_n  = cur_div;
    pend_div_n = pend_div;
    pend_vld_n = pend_vld;
    cnt_n      = cnt;
    done_cnt_n = done_cnt;

    accept   = div_valid_i & div_ready_o;
    err_n    = accept & (div_i < TWO);
    boundary = (state == RUN) && (cnt == (cur_div - ONE));

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (pend_vld) begin
          cur_div_n  = pend_div;
          pend_vld_n = 1'b0;
          done_cnt_n = '0;
        end
        if (en_i) state_n = RUN;
      end
      RUN: begin
        if (boundary) begin
          cnt_n = '0;
          if (pend_vld) begin
            cur_div_n  = pend_div;
            pend_vld_n = 1'b0;
            done_cnt_n = '0;
          end else if (done_cnt < DONE_MAX) begin
            done_cnt_n = done_cnt + 4'd1;
          end
          if (!en_i) state_n = IDLE;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    if (accept && (div_i >= TWO)) begin
      pend_div_n = div_i;
      pend_vld_n = 1'b1;
    end

    half_n  = ({1'b0, cur_div_n} + ONE_WIDE) >> 1;
    clk_n   = (state_n == RUN) && ({1'b0, cnt_n} < half_n);
    trg_n   = (state_n == RUN) && (cnt_n == (cur_div_n - ONE));
    ready_n = ~pend_vld_n;
    done_n  = (done_cnt_n == DONE_MAX);
  end

  // State and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      cur_div     <= DEF_DIV;
      pend_div    <= '0;
      pend_vld    <= 1'b0;
      cnt         <= '0;
      done_cnt    <= '0;
      clk_o       <= 1'b0;
      clk_trg_o   <= 1'b0;
      div_ready_o <= 1'b1;
      div_err_o   <= 1'b0;
      div_done_o  <= 1'b0;
    end else begin
      state       <= state_n;
      cur_div     <= cur_div_n;
      pend_div    <= pend_div_n;
      pend_vld    <= pend_vld_n;
      cnt         <= cnt_n;
      done_cnt    <= done_cnt_n;
      clk_o       <= clk_n;
      clk_trg_o   <= trg_n;
      div_ready_o <= ready_n;
      div_err_o   <= err_n;
      div_done_o  <= done_n;
    end
  end

  assign clk_cnt_o = cnt;

endmodule
